// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI target with clk-domain oversampling, all cpol/cpha modes, RX/TX byte FIFOs

module spi_slave_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count, count_n;
   logic          do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   always_comb begin
      count_n = count;
      if (do_push) count_n = count_n + CNT_ONE;
      if (do_pop)  count_n = count_n - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + PTR_ONE;
         end
         if (do_pop) rptr <= rptr + PTR_ONE;
         count <= count_n;
         empty <= (count_n == '0);
         full  <= (count_n == CNT_FULL);
      end
   end
endmodule

module spi_slave #(
   parameter int FIFO_SIZE   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ss,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       cpol,
   input  logic       cpha,
   output logic       busy,
   output logic       rx_overrun,
   output logic       tx_underrun,
   output logic       rx_fifo_full,
   output logic       rx_fifo_empty,
   output logic [7:0] rx_fifo_rdata,
   input  logic       rx_fifo_pop,
   output logic       tx_fifo_full,
   output logic       tx_fifo_empty,
   input  logic [7:0] tx_fifo_wdata,
   input  logic       tx_fifo_push
);
   typedef enum logic {IDLE, SELECTED} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
   logic                   ss_s, sck_s, mosi_s, ss_q, sck_q;
   logic                   ss_fall, lead, trail;
   logic                   cpol_l, cpha_l;
   logic [3:0]             bit_cnt;
   logic [6:0]             rx_shift, tx_shift;
   logic                   load_req, rx_done, tx_pop, rx_push;
   logic [7:0]             tx_rdata, load_byte, rx_wdata;

   assign ss_s    = ss_sync[SYNC_STAGES-1];
   assign sck_s   = sck_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign busy    = ~ss_s;
   assign ss_fall = ss_q & ~ss_s;
   assign lead    = (sck_s ^ sck_q) & (sck_s != cpol_l);
   assign trail   = (sck_s ^ sck_q) & (sck_s == cpol_l);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         ss_q      <= 1'b1;
         sck_q     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_q      <= ss_s;
         sck_q     <= sck_s;
      end
   end

   // cpha=1 fetches its first byte on the first leading edge, so selection only preloads for cpha=0
   always_comb begin
      load_req = 1'b0;
      rx_done  = 1'b0;
      if (state == IDLE) begin
         load_req = ss_fall & ~cpha;
      end else if (!ss_s) begin
         if (!cpha_l) begin
            rx_done  = lead & (bit_cnt == 4'd7);
            load_req = trail & (bit_cnt == 4'd8);
         end else begin
            load_req = lead & (bit_cnt == 4'd0);
            rx_done  = trail & (bit_cnt == 4'd7);
         end
      end
   end

   assign tx_pop    = load_req & ~tx_fifo_empty;
   assign load_byte = tx_fifo_empty ? 8'h00 : tx_rdata;
   assign rx_push   = rx_done & ~rx_fifo_full;
   assign rx_wdata  = {rx_shift, mosi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
      end else begin
         rx_overrun  <= rx_done & rx_fifo_full;
         tx_underrun <= load_req & tx_fifo_empty;
         case (state)
            IDLE: begin
               miso    <= 1'b0;
               miso_oe <= 1'b0;
               if (ss_fall) begin
                  state    <= SELECTED;
                  cpol_l   <= cpol;
                  cpha_l   <= cpha;
                  bit_cnt  <= '0;
                  rx_shift <= '0;
                  miso_oe  <= 1'b1;
                  if (!cpha) begin
                     tx_shift <= load_byte[6:0];
                     miso     <= load_byte[7];
                  end
               end
            end
            SELECTED: begin
               if (ss_s) begin
                  state   <= IDLE;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                  bit_cnt <= '0;
               end else if (!cpha_l) begin
                  if (lead) begin
                     rx_shift <= {rx_shift[5:0], mosi_s};
                     bit_cnt  <= bit_cnt + 4'd1;
                  end
                  if (trail) begin
                     if (bit_cnt == 4'd8) begin
                        bit_cnt  <= '0;
                        tx_shift <= load_byte[6:0];
                        miso     <= load_byte[7];
                     end else begin
                        miso     <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                     end
                  end
               end else begin
                  if (lead) begin
                     if (bit_cnt == 4'd0) begin
                        tx_shift <= load_byte[6:0];
                        miso     <= load_byte[7];
                     end else begin
                        miso     <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                     end
                  end
                  if (trail) begin
                     rx_shift <= {rx_shift[5:0], mosi_s};
                     bit_cnt  <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   spi_slave_fifo #(.DEPTH(FIFO_SIZE)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .wdata (rx_wdata),
      .pop   (rx_fifo_pop),
      .rdata (rx_fifo_rdata),
      .full  (rx_fifo_full),
      .empty (rx_fifo_empty)
   );

   spi_slave_fifo #(.DEPTH(FIFO_SIZE)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_fifo_push),
      .wdata (tx_fifo_wdata),
      .pop   (tx_pop),
      .rdata (tx_rdata),
      .full  (tx_fifo_full),
      .empty (tx_fifo_empty)
   );
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave with an SPI master model and byte scoreboards

module tb_spi_slave;
   localparam int HALF = 8;
   localparam int FSZ  = 8;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       ss = 1'b1, sck = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic       rx_fifo_pop = 1'b0, tx_fifo_push = 1'b0;
   logic [7:0] tx_fifo_wdata = 8'h00;
   logic       miso, miso_oe, busy, rx_overrun, tx_underrun;
   logic       rx_fifo_full, rx_fifo_empty, tx_fifo_full, tx_fifo_empty;
   logic [7:0] rx_fifo_rdata;

   int errors = 0, checks = 0, ovr_cnt = 0, udr_cnt = 0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_miso_q[$];

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
      int         exp_udr;
   } vec_t;
   vec_t vecs[4];

   spi_slave #(.FIFO_SIZE(FSZ), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ss            (ss),
      .sck           (sck),
      .mosi          (mosi),
      .miso          (miso),
      .miso_oe       (miso_oe),
      .cpol          (cpol),
      .cpha          (cpha),
      .busy          (busy),
      .rx_overrun    (rx_overrun),
      .tx_underrun   (tx_underrun),
      .rx_fifo_full  (rx_fifo_full),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_rdata (rx_fifo_rdata),
      .rx_fifo_pop   (rx_fifo_pop),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_fifo_wdata (tx_fifo_wdata),
      .tx_fifo_push  (tx_fifo_push)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_overrun)  ovr_cnt = ovr_cnt + 1;
      if (tx_underrun) udr_cnt = udr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_fifo_wdata = d;
      tx_fifo_push  = 1'b1;
      wait_clk(1);
      tx_fifo_push  = 1'b0;
   endtask

   task automatic set_mode(input logic p, input logic h);
      cpol = p;
      cpha = h;
      sck  = p;
      wait_clk(HALF);
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      wait_clk(HALF);
      chk("busy_in_frame", busy, 1);
      chk("miso_oe_in_frame", miso_oe, 1);
   endtask

   task automatic frame_end();
      wait_clk(HALF);
      ss = 1'b1;
      wait_clk(HALF);
      chk("busy_after_frame", busy, 0);
      chk("miso_oe_after_frame", miso_oe, 0);
      chk("miso_after_frame", miso, 0);
   endtask

   // Master model: cpha=0 samples on the leading edge, cpha=1 on the trailing edge
   task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int k = 0; k < n; k++) begin
         if (!cpha) begin
            mosi = tx[7-k];
            wait_clk(HALF);
            sck = ~cpol;
            rx[7-k] = miso;
            wait_clk(HALF);
            sck = cpol;
         end else begin
            sck = ~cpol;
            mosi = tx[7-k];
            wait_clk(HALF);
            sck = cpol;
            rx[7-k] = miso;
            wait_clk(HALF);
         end
      end
   endtask

   task automatic xfer_check(input logic [7:0] tx);
      logic [7:0] r, e;
      xfer_bits(tx, 8, r);
      e = exp_miso_q.pop_front();
      chk("miso_byte", r, e);
   endtask

   task automatic pop_check();
      logic [7:0] e;
      e = exp_rx_q.pop_front();
      chk("rx_fifo_rdata", rx_fifo_rdata, e);
      rx_fifo_pop = 1'b1;
      wait_clk(1);
      rx_fifo_pop = 1'b0;
      wait_clk(1);
   endtask

   task automatic drain_rx();
      for (int g = 0; g < FSZ + 4 && !rx_fifo_empty; g++) begin
         if (exp_rx_q.size() == 0) begin
            chk("rx_extra_entry", rx_fifo_empty, 1);
            rx_fifo_pop = 1'b1;
            wait_clk(1);
            rx_fifo_pop = 1'b0;
            wait_clk(1);
         end else begin
            pop_check();
         end
      end
      chk("rx_scoreboard_left", exp_rx_q.size(), 0);
      chk("rx_empty_after_drain", rx_fifo_empty, 1);
      exp_rx_q.delete();
   endtask

   initial begin
      int ub, ob;
      logic [7:0] r, head;

      vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_udr: 1};
      vecs[1] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81, exp_udr: 0};
      vecs[2] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81, exp_udr: 1};
      vecs[3] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81, exp_udr: 0};

      wait_clk(4);
      chk("rst_miso", miso, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rx_overrun", rx_overrun, 0);
      chk("rst_tx_underrun", tx_underrun, 0);
      chk("rst_rx_empty", rx_fifo_empty, 1);
      chk("rst_tx_empty", tx_fifo_empty, 1);
      chk("rst_rx_full", rx_fifo_full, 0);
      chk("rst_tx_full", tx_fifo_full, 0);
      rst_n = 1'b1;
      wait_clk(4);

      // Mode table: the cpha=0 reload after the last byte finds the TX FIFO empty
      for (int v = 0; v < 4; v++) begin
         set_mode(vecs[v].cpol, vecs[v].cpha);
         push_tx(vecs[v].tx);
         exp_miso_q.push_back(vecs[v].exp_miso);
         exp_rx_q.push_back(vecs[v].exp_rx);
         ub = udr_cnt;
         ob = ovr_cnt;
         frame_begin();
         xfer_check(vecs[v].mosi);
         frame_end();
         chk("table_underruns", udr_cnt - ub, vecs[v].exp_udr);
         chk("table_overruns", ovr_cnt - ob, 0);
         chk("table_tx_empty", tx_fifo_empty, 1);
         drain_rx();
      end

      // Three-byte burst from two queued bytes
      set_mode(1'b0, 1'b0);
      push_tx(8'h11);
      push_tx(8'h22);
      exp_miso_q.push_back(8'h11);
      exp_miso_q.push_back(8'h22);
      exp_miso_q.push_back(8'h00);
      ub = udr_cnt;
      frame_begin();
      for (int i = 0; i < 3; i++) begin
         exp_rx_q.push_back(8'hC1 + 8'(i));
         xfer_check(8'hC1 + 8'(i));
      end
      frame_end();
      chk("burst_underruns", udr_cnt - ub, 2);
      drain_rx();

      // RX overrun: fill, overflow, pop one, accept again
      frame_begin();
      for (int i = 0; i < FSZ; i++) begin
         exp_rx_q.push_back(8'h10 + 8'(i));
         exp_miso_q.push_back(8'h00);
         xfer_check(8'h10 + 8'(i));
      end
      frame_end();
      chk("rx_full_after_fill", rx_fifo_full, 1);
      ob = ovr_cnt;
      head = exp_rx_q[0];
      exp_miso_q.push_back(8'h00);
      frame_begin();
      xfer_check(8'hF0);
      frame_end();
      chk("overrun_pulses", ovr_cnt - ob, 1);
      chk("overrun_head_kept", rx_fifo_rdata, head);
      chk("overrun_still_full", rx_fifo_full, 1);
      pop_check();
      exp_rx_q.push_back(8'h0F);
      exp_miso_q.push_back(8'h00);
      frame_begin();
      xfer_check(8'h0F);
      frame_end();
      chk("overrun_no_more", ovr_cnt - ob, 1);
      drain_rx();

      // Partial frame discarded, next frame aligned
      frame_begin();
      xfer_bits(8'hFF, 5, r);
      frame_end();
      chk("partial_no_push", rx_fifo_empty, 1);
      exp_rx_q.push_back(8'h55);
      exp_miso_q.push_back(8'h00);
      frame_begin();
      xfer_check(8'h55);
      frame_end();
      drain_rx();

      // Reset in the middle of a byte
      push_tx(8'hAA);
      push_tx(8'hBB);
      push_tx(8'hCC);
      frame_begin();
      xfer_bits(8'h5A, 3, r);
      rst_n = 1'b0;
      wait_clk(2);
      chk("midrst_miso", miso, 0);
      chk("midrst_miso_oe", miso_oe, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_underrun", tx_underrun, 0);
      chk("midrst_rx_empty", rx_fifo_empty, 1);
      chk("midrst_tx_empty", tx_fifo_empty, 1);
      ss  = 1'b1;
      sck = cpol;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
      ub = udr_cnt;
      exp_rx_q.push_back(8'h96);
      exp_miso_q.push_back(8'h00);
      frame_begin();
      xfer_check(8'h96);
      frame_end();
      chk("postrst_underruns", udr_cnt - ub, 2);
      drain_rx();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
